regfile_bypass: RTL and testbench

Parametrised general-purpose register file for the MIPS32 datapath: two combinational read ports, one synchronous write port, hardwired-zero register 0, asynchronous clear of all registers, and a per-register busy scoreboard that the decode stage uses to stall on outstanding multi-cycle results (loads, mult/div). It sits between decode (reads, busy checks) and write-back (writes). It is the drop-in successor of the current fixed 32x32 register file.

---
 rtl/regfile_bypass.sv | 112 +++++++++++
 tb/tb_regfile_bypass.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass.sv
// MIPS32 GPR file: 2 combinational read ports, 1 write port, busy scoreboard.
// Optional same-cycle write-through forwarding under REGFILE_BYPASS_EN.

module regfile_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [2**ADDR_W-1:0]             busy,
  input  logic [ADDR_W-1:0]                rdAddr,
  input  logic                             fwdEn,
  input  logic [DATA_W-1:0]                fwdData,
  input  logic                             fwdBusy,
  output logic [DATA_W-1:0]                rdData,
  output logic                             rdBusy
);
  logic isZero;
  assign isZero = (ZERO_REG != 0) && (rdAddr == '0);

  always_comb begin
    rdData = regs[rdAddr];
    rdBusy = busy[rdAddr];
    if (fwdEn) begin
      rdData = fwdData;
      rdBusy = fwdBusy;
    end
    if (isZero) begin
      rdData = '0;
      rdBusy = 1'b0;
    end
  end
endmodule

module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              busy1,
  output logic              busy2
);
  localparam int DEPTH   = 2**ADDR_W;
  localparam int NUM_RD  = 2;

  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic [DEPTH-1:0]              busy;
  logic                          wrEn, setEn;
  logic [NUM_RD-1:0][ADDR_W-1:0] rdAddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdData;
  logic [NUM_RD-1:0]             rdBusy, fwdEn, fwdBusy;

  assign wrEn  = reg_write && !((ZERO_REG != 0) && (write_addr == '0));
  assign setEn = busy_set  && !((ZERO_REG != 0) && (busy_addr  == '0));

  // Set is applied after clear so a new producer supersedes the completing one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      if (wrEn) begin
        regs[write_addr] <= write_data;
        busy[write_addr] <= 1'b0;
      end
      if (setEn)
        busy[busy_addr] <= 1'b1;
    end
  end

  assign rdAddr = {read_addr2, read_addr1};

  genvar i;
  generate
    for (i = 0; i < NUM_RD; i++) begin : gRd
`ifdef REGFILE_BYPASS_EN
      // Forwarding is held off during reset so reads stay zero while rst_n=0.
      assign fwdEn[i]   = rst_n && wrEn && (write_addr == rdAddr[i]);
      assign fwdBusy[i] = setEn && (busy_addr == rdAddr[i]);
`else
      assign fwdEn[i]   = 1'b0;
      assign fwdBusy[i] = 1'b0;
`endif
      regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) uRd (
        .regs    (regs),
        .busy    (busy),
        .rdAddr  (rdAddr[i]),
        .fwdEn   (fwdEn[i]),
        .fwdData (write_data),
        .fwdBusy (fwdBusy[i]),
        .rdData  (rdData[i]),
        .rdBusy  (rdBusy[i])
      );
    end
  endgenerate

  assign read_data1 = rdData[0];
  assign read_data2 = rdData[1];
  assign busy1      = rdBusy[0];
  assign busy2      = rdBusy[1];
endmodule

// File: tb/tb_regfile_bypass.sv
// Scoreboard bench for regfile_bypass: default 32x32 instance plus a 16x8 no-zero-reg instance.
module tb_regfile_bypass;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        we, bs, b1, b2;
  logic [4:0]  wa, ra1, ra2, ba;
  logic [31:0] wd, rd1, rd2;

  logic        swe, sbs, sb1, sb2;
  logic [2:0]  swa, sra1, sra2, sba;
  logic [15:0] swd, srd1, srd2;

  regfile_bypass dut (
    .clk(clk), .rst_n(rst_n), .reg_write(we), .write_addr(wa), .write_data(wd),
    .read_addr1(ra1), .read_addr2(ra2), .read_data1(rd1), .read_data2(rd2),
    .busy_set(bs), .busy_addr(ba), .busy1(b1), .busy2(b2)
  );

  regfile_bypass #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dutS (
    .clk(clk), .rst_n(rst_n), .reg_write(swe), .write_addr(swa), .write_data(swd),
    .read_addr1(sra1), .read_addr2(sra2), .read_data1(srd1), .read_data2(srd2),
    .busy_set(sbs), .busy_addr(sba), .busy1(sb1), .busy2(sb2)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int nChecks = 0;
  int nFail   = 0;

  task automatic expect_(string n, int sel, logic [31:0] e);
    chk_t c;
    c.name = n; c.sel = sel; c.exp = e;
    q.push_back(c);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Monitor: outputs are combinational, so every negedge drains what the stimulus queued.
  initial begin
    chk_t c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        c = q.pop_front();
        case (c.sel)
          0: act = rd1;
          1: act = rd2;
          2: act = {31'd0, b1};
          3: act = {31'd0, b2};
          4: act = {16'd0, srd1};
          5: act = {16'd0, srd2};
          6: act = {31'd0, sb1};
          default: act = {31'd0, sb2};
        endcase
        nChecks++;
        if (act !== c.exp) begin
          nFail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    we = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0; bs = 0; ba = 0;
    swe = 0; swa = 0; swd = 0; sra1 = 0; sra2 = 0; sbs = 0; sba = 0;
    expect_("reset_rd1", 0, 0);  expect_("reset_rd2", 1, 0);
    expect_("reset_b1", 2, 0);   expect_("reset_b2", 3, 0);
    cyc(); cyc();
    rst_n = 1'b1;

    we = 1; wa = 7; wd = 32'hDEADBEEF; ra1 = 7; ra2 = 0;
    expect_("wr_r7_same", 0, BYP ? 32'hDEADBEEF : 32'h0);
    cyc();
    we = 1; wa = 0; wd = 32'h12345678;
    expect_("r7_next", 0, 32'hDEADBEEF);
    expect_("r0_bypass_ignored", 1, 0);
    cyc();
    we = 0;
    expect_("r0_still_zero", 1, 0);

    cyc();
    we = 1; wa = 9; wd = 32'hCAFEF00D; ra2 = 9;
    expect_("byp_r9_same", 1, BYP ? 32'hCAFEF00D : 32'h0);
    expect_("byp_r9_busy", 3, 0);
    cyc();
    we = 0;
    expect_("r9_next", 1, 32'hCAFEF00D);

    cyc();
    bs = 1; ba = 3; ra1 = 3; ra2 = 3;
    expect_("busy_set_same", 2, 0);
    cyc();
    bs = 0;
    expect_("busy_r3_b1", 2, 1);
    expect_("busy_r3_b2", 3, 1);
    cyc();
    we = 1; wa = 3; wd = 32'h55;
    expect_("clr_r3_same_b", 2, BYP ? 32'd0 : 32'd1);
    expect_("clr_r3_same_d", 0, BYP ? 32'h55 : 32'h0);
    cyc();
    we = 0;
    expect_("clr_r3_next_b", 2, 0);
    expect_("clr_r3_next_d", 0, 32'h55);

    cyc();
    we = 1; wa = 5; wd = 32'hA5A5A5A5; bs = 1; ba = 5; ra1 = 5; ra2 = 5;
    expect_("coll_same_b", 2, BYP ? 32'd1 : 32'd0);
    expect_("coll_same_d", 0, BYP ? 32'hA5A5A5A5 : 32'h0);
    cyc();
    we = 0; bs = 0;
    expect_("coll_b1", 2, 1);
    expect_("coll_b2", 3, 1);
    expect_("coll_d", 1, 32'hA5A5A5A5);

    cyc();
    bs = 1; ba = 0; ra1 = 0;
    expect_("bs_r0_same", 2, 0);
    cyc();
    bs = 0;
    expect_("bs_r0_ignored", 2, 0);

    // Mid-run reset with a pending write and set: both must be lost.
    cyc();
    rst_n = 1'b0; we = 1; wa = 7; wd = 32'hFFFFFFFF; bs = 1; ba = 9; ra1 = 5; ra2 = 7;
    expect_("rst_mid_rd1", 0, 0); expect_("rst_mid_rd2", 1, 0);
    expect_("rst_mid_b1", 2, 0);  expect_("rst_mid_b2", 3, 0);
    cyc();
    rst_n = 1'b1; we = 0; bs = 0; ra1 = 7; ra2 = 9;
    expect_("rst_lost_wr", 0, 0);
    expect_("rst_lost_set", 3, 0);

    // Small instance: register 0 is ordinary.
    cyc();
    swe = 1; swa = 0; swd = 16'hBEEF; sra1 = 0;
    expect_("s_r0_same", 4, BYP ? 32'hBEEF : 32'h0);
    cyc();
    swa = 7; swd = 16'h7777; sra2 = 0;
    expect_("s_r0_read", 4, 32'hBEEF);
    cyc();
    swe = 0; sra2 = 7;
    expect_("s_r7_read", 5, 32'h7777);
    for (int i = 1; i < 7; i++) begin
      cyc();
      sra1 = i[2:0];
      expect_($sformatf("s_noalias_r%0d", i), 4, 0);
    end
    cyc();
    sbs = 1; sba = 0; sra1 = 0;
    cyc();
    sbs = 0;
    expect_("s_busy_r0", 6, 1);
    expect_("s_busy_r7", 7, 0);

    cyc();
    @(negedge clk); #1;
    if (q.size() != 0) begin
      nChecks++; nFail++;
      $display("FAIL drain: %0d checks left unconsumed, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
